register_file: RTL and testbench
================================

Name: register_file

Overview:
- 16 x 32-bit general register file for the DMA-capable processor core.
- Provides two combinational read ports.
- Has one synchronous write port, and its write source is selected by the instruction opcode: ALU add/sub result, or a word loaded from the shared data bus.
- Drives the shared bidirectional data bus for register-store instructions, and releases it (high-Z) otherwise.

Parameters:
- NREGS, 16, number of registers; index width is 4 bits.
- DW, 32, register and data bus width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ReadData1  output  32  contents of R[Readreg1].
- ReadData2  output  32  contents of R[Readreg2].
- Readreg1  input  4  read port 1 index; ALU operand A.
- Readreg2  input  4  read port 2 index; ALU operand B and store source.
- Writereg  input  4  write index.
- source  input  8  transfer source address; used only by the optional feature.
- destination  input  8  transfer destination address; used only by the optional feature.
- RegWrite  input  1  write enable from the decoder.
- op  input  2  opcode: 00 store/out, 01 load/in, 10 add, 11 sub.
- type  input  2  transfer type: 00 memory, 01 memory<->I/O block, 10 memory->memory, 11 I/O single word.
- data  inout  32  shared data bus.

Behaviour:
- Reset: when rst=1 at a rising clk edge, R0..R15 are cleared to 0. Reset has priority over any write in the same cycle.
- Reads:
  - ReadData1 = R[Readreg1] and ReadData2 = R[Readreg2], purely combinational.
  - R0 always reads 0.
  - Without the optional feature there is no bypass: a read of the register being written returns the old value until the edge.
- Write: on rising clk with rst=0 and RegWrite=1, the destination R[Writereg] is updated as follows.
  - op=10: R[Readreg1] + R[Readreg2], modulo 2^32; carry is discarded.
  - op=11: R[Readreg1] - R[Readreg2], modulo 2^32 (two's complement wrap); borrow is discarded.
  - op=01 with type=00 or 11: the value on data sampled at the edge.
  - op=01 with type=01 or 10: no write. These are bus-to-bus transfers and must not touch the register file.
  - op=00: no write, even if RegWrite=1.
- Writes to Writereg=0 are discarded; R0 stays 0.
- RegWrite=0 means no write for any op.
- Bus drive:
  - When op=00 and type is 00 or 11, data is driven combinationally with R[Readreg2].
  - For every other op/type combination, data is high-Z, and the block only samples it.
  - The bus is never driven in the same cycle it is sampled for a load.
- One write per cycle, single-cycle latency: a value written at edge N is visible on the read ports immediately after edge N.
- Simultaneous read and write of the same index return the pre-edge value.
- X or Z on data during a load is stored as-is; there is no checking.

Optional Feature:
- Macro REGFILE_ADDR_TAG_EN.
- When defined:
  - The block keeps two internal 8-bit tag registers, last_src and last_dst, both reset to 0.
  - On every accepted load (op=01, type 00/11), last_src <= source.
  - On every store drive cycle (op=00, type 00/11), last_dst <= destination.
  - A load whose source is 0 is discarded (no register write).
  - Read ports gain write-to-read bypass: a read of the index being written this cycle returns the new value.
- When undefined: source and destination are ignored, there are no tag registers, and there is no bypass.

Test Plan:
- Assert rst for 1 cycle, then release; read all 16 indices -> every ReadData = 0; data is high-Z with op=01.
- Load: op=01, type=00, RegWrite=1, Writereg=3, data=32'hDEADBEEF, then one edge -> Readreg1=3 gives ReadData1=32'hDEADBEEF. Repeat with type=01 -> R3 unchanged.
- Add/sub wrap, with R1=32'hFFFFFFFF and R2=1:
  - op=10, Writereg=4 -> R4=0.
  - op=11, Readreg1=2, Readreg2=1, Writereg=5 -> R5=2.
- Store drive: op=00, type=11, Readreg2=3 -> data=32'hDEADBEEF; switch to op=01 -> data=Z. With op=00 and RegWrite=1 -> no register changes.
- R0 protection: load 32'h12345678 into Writereg=0 -> ReadData1 with Readreg1=0 stays 0.
- Reset mid-operation: op=10, RegWrite=1 and rst=1 in the same cycle -> all registers 0, no write.

Source files
------------

// File: rtl/register_file.sv
// 16 x 32 general register file: two combinational read ports, one write port fed by ALU add/sub or bus load.
// Latency: reads are combinational; a write at edge N is visible on the read ports right after edge N.
// Backpressure: none; the shared data bus is driven only for word stores and released (high-Z) otherwise.
// Optional feature macro: REGFILE_ADDR_TAG_EN (source/destination tag registers, zero-source load drop, write-to-read bypass).
module register_file #(
  parameter int NREGS = 16,
  parameter int DW    = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [DW-1:0] ReadData1,
  output logic [DW-1:0] ReadData2,
  input  logic [AW-1:0] Readreg1,
  input  logic [AW-1:0] Readreg2,
  input  logic [AW-1:0] Writereg,
  input  logic [7:0]    source,
  input  logic [7:0]    destination,
  input  logic          RegWrite,
  input  logic [1:0]    op,
  // Transfer type; "type" is a reserved word in SystemVerilog, hence the name.
  input  logic [1:0]    xfer_type,
  inout  wire  [DW-1:0] data
);

  typedef enum logic [1:0] {
    OP_STORE = 2'b00,
    OP_LOAD  = 2'b01,
    OP_ADD   = 2'b10,
    OP_SUB   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    XT_MEM      = 2'b00,
    XT_MEM_IO   = 2'b01,
    XT_MEM_MEM  = 2'b10,
    XT_IO_WORD  = 2'b11
  } xfer_e;

  logic [DW-1:0] regs [NREGS];

  logic [DW-1:0] rd1_raw;
  logic [DW-1:0] rd2_raw;
  logic          word_xfer;
  logic          is_load;
  logic          is_store;
  logic          load_ok;
  logic          wr_en;
  logic [DW-1:0] wr_dat;
  op_e           op_q;
  xfer_e         xt_q;

  assign op_q = op_e'(op);
  assign xt_q = xfer_e'(xfer_type);

  // Raw register reads; R0 is hard-wired to zero regardless of storage contents.
  always_comb begin
    rd1_raw = '0;
    rd2_raw = '0;
    if (Readreg1 != '0) rd1_raw = regs[Readreg1];
    if (Readreg2 != '0) rd2_raw = regs[Readreg2];
  end

  // Opcode/transfer decode. Only single-word transfers touch the register file or the bus;
  // block and memory-to-memory transfers pass between other agents on the bus.
  always_comb begin
    word_xfer = (xt_q == XT_MEM) || (xt_q == XT_IO_WORD);
    is_load   = (op_q == OP_LOAD)  && word_xfer;
    is_store  = (op_q == OP_STORE) && word_xfer;
`ifdef REGFILE_ADDR_TAG_EN
    load_ok   = is_load && (source != 8'd0);
`else
    load_ok   = is_load;
`endif
  end

  // Write source select and enable. ALU operands come from the raw reads so the
  // bypass path (when enabled) can never feed back into its own write data.
  always_comb begin
    wr_dat = '0;
    wr_en  = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        wr_dat = rd1_raw + rd2_raw;
        wr_en  = 1'b1;
      end
      OP_SUB: begin
        wr_dat = rd1_raw - rd2_raw;
        wr_en  = 1'b1;
      end
      OP_LOAD: begin
        wr_dat = data;
        wr_en  = load_ok;
      end
      OP_STORE: begin
        wr_dat = '0;
        wr_en  = 1'b0;
      end
      default: begin
        wr_dat = '0;
        wr_en  = 1'b0;
      end
    endcase
    // Writes to R0 are dropped so it keeps reading zero.
    if (!RegWrite || (Writereg == '0)) wr_en = 1'b0;
  end

  // Register array update; reset clears every entry and overrides a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[Writereg] <= wr_dat;
    end
  end

  // Bus drive: only word stores put R[Readreg2] on the bus; loads therefore never see our own drive.
  assign data = is_store ? rd2_raw : {DW{1'bz}};

`ifdef REGFILE_ADDR_TAG_EN
  logic [7:0] last_src;
  logic [7:0] last_dst;
  logic       unused_tags;

  // Remember the bus address of the most recent word load and word store.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_src <= 8'd0;
      last_dst <= 8'd0;
    end else begin
      if (is_load)  last_src <= source;
      if (is_store) last_dst <= destination;
    end
  end

  // Tags are kept for observation only; nothing inside the block consumes them.
  assign unused_tags = ^{last_src, last_dst};

  // Read ports with write-to-read bypass: a read of the index being written sees the new value.
  always_comb begin
    ReadData1 = rd1_raw;
    ReadData2 = rd2_raw;
    if (wr_en && (Writereg == Readreg1)) ReadData1 = wr_dat;
    if (wr_en && (Writereg == Readreg2)) ReadData2 = wr_dat;
  end
`else
  logic unused_addr;

  // Transfer addresses only matter when tag tracking is built in.
  assign unused_addr = ^{source, destination};

  // Read ports without bypass: a same-cycle write is seen only after the edge.
  always_comb begin
    ReadData1 = rd1_raw;
    ReadData2 = rd2_raw;
  end
`endif

endmodule

// File: tb/tb_register_file.sv
`timescale 1ns/1ps
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [3:0]  rr1;
  logic [3:0]  rr2;
  logic [3:0]  wr;
  logic [7:0]  src;
  logic [7:0]  dst;
  logic        reg_write;
  logic [1:0]  op;
  logic [1:0]  xt;
  wire  [31:0] data;
  logic        tb_en;
  logic [31:0] tb_val;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  assign data = tb_en ? tb_val : 32'bz;

  register_file dut (
    .clk         (clk),
    .rst         (rst),
    .ReadData1   (rd1),
    .ReadData2   (rd2),
    .Readreg1    (rr1),
    .Readreg2    (rr2),
    .Writereg    (wr),
    .source      (src),
    .destination (dst),
    .RegWrite    (reg_write),
    .op          (op),
    .xfer_type   (xt),
    .data        (data)
  );

  task automatic expect_val(input string tag, input logic [31:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd1_check(input string tag, input logic [3:0] idx, input logic [31:0] e);
    rr1 = idx;
    #1;
    expect_val(tag, e);
    check(rd1);
  endtask

  task automatic rd2_check(input string tag, input logic [3:0] idx, input logic [31:0] e);
    rr2 = idx;
    #1;
    expect_val(tag, e);
    check(rd2);
  endtask

  task automatic load(input logic [3:0] w, input logic [31:0] val, input logic [1:0] t);
    op        = 2'b01;
    xt        = t;
    wr        = w;
    tb_en     = 1'b1;
    tb_val    = val;
    reg_write = 1'b1;
    tick();
    reg_write = 1'b0;
  endtask

  task automatic alu(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b, input logic [3:0] w);
    op        = o;
    rr1       = a;
    rr2       = b;
    wr        = w;
    reg_write = 1'b1;
    tick();
    reg_write = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    rr1       = 4'd0;
    rr2       = 4'd0;
    wr        = 4'd0;
    src       = 8'h21;
    dst       = 8'h42;
    reg_write = 1'b0;
    op        = 2'b01;
    xt        = 2'b00;
    tb_en     = 1'b1;
    tb_val    = 32'h0;

    // Reset, then every index reads zero on both ports.
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd1_check("reset_rd1", 4'(i), 32'h0);
      rd2_check("reset_rd2", 4'(15 - i), 32'h0);
    end

    // With op=01 the block must not drive: the bench's own value must appear intact.
    tb_val = 32'hA5A5_5A5A;
    #1;
    expect_val("load_bus_released", 32'hA5A5_5A5A);
    check(data);

    // Word load into R3; before the edge the old value is still returned.
    op = 2'b01; xt = 2'b00; wr = 4'd3; tb_val = 32'hDEAD_BEEF; reg_write = 1'b1;
`ifdef REGFILE_ADDR_TAG_EN
    rd1_check("pre_edge_bypass", 4'd3, 32'hDEAD_BEEF);
`else
    rd1_check("pre_edge_no_bypass", 4'd3, 32'h0);
`endif
    tick();
    reg_write = 1'b0;
    rd1_check("load_r3", 4'd3, 32'hDEAD_BEEF);

    // Block and memory-to-memory transfers leave the register file alone.
    load(4'd3, 32'h1111_1111, 2'b01);
    rd1_check("xfer01_no_write", 4'd3, 32'hDEAD_BEEF);
    load(4'd3, 32'h2222_2222, 2'b10);
    rd1_check("xfer10_no_write", 4'd3, 32'hDEAD_BEEF);
    load(4'd6, 32'h0000_CAFE, 2'b11);
    rd2_check("load_io_word_r6", 4'd6, 32'h0000_CAFE);

    // Operands for the add/sub wrap cases.
    load(4'd1, 32'hFFFF_FFFF, 2'b00);
    load(4'd2, 32'h0000_0001, 2'b00);
    rd1_check("load_r1", 4'd1, 32'hFFFF_FFFF);
    rd2_check("load_r2", 4'd2, 32'h0000_0001);

    alu(2'b10, 4'd1, 4'd2, 4'd4);
    rd1_check("add_wrap_r4", 4'd4, 32'h0);
    alu(2'b10, 4'd1, 4'd1, 4'd7);
    rd1_check("add_r7", 4'd7, 32'hFFFF_FFFE);
    alu(2'b11, 4'd2, 4'd1, 4'd5);
    rd1_check("sub_wrap_r5", 4'd5, 32'h0000_0002);
    alu(2'b11, 4'd1, 4'd2, 4'd8);
    rd1_check("sub_r8", 4'd8, 32'hFFFF_FFFE);
    alu(2'b10, 4'd3, 4'd6, 4'd11);
    rd1_check("add_r11", 4'd11, 32'hDEAD_BEEF + 32'h0000_CAFE);

    // RegWrite low blocks the write for an ALU op.
    op = 2'b10; rr1 = 4'd1; rr2 = 4'd1; wr = 4'd9; reg_write = 1'b0;
    tick();
    rd1_check("regwrite_low_r9", 4'd9, 32'h0);

    // Store drive: release the bench driver first, then select the store.
    tb_en = 1'b0;
    op = 2'b00; xt = 2'b11; rr2 = 4'd3;
    #1;
    expect_val("store_io_r3", 32'hDEAD_BEEF);
    check(data);
    xt = 2'b00; rr2 = 4'd1;
    #1;
    expect_val("store_mem_r1", 32'hFFFF_FFFF);
    check(data);

    // Store with a block transfer type must not drive.
    xt = 2'b01; tb_en = 1'b1; tb_val = 32'h0F0F_F0F0;
    #1;
    expect_val("store_blk_released", 32'h0F0F_F0F0);
    check(data);

    // Switching to a load releases the bus.
    op = 2'b01; xt = 2'b00; tb_val = 32'h3C3C_C3C3;
    #1;
    expect_val("load_after_store_released", 32'h3C3C_C3C3);
    check(data);

    // A store with RegWrite=1 changes no register.
    tb_en = 1'b0;
    op = 2'b00; xt = 2'b11; rr2 = 4'd6; wr = 4'd3; reg_write = 1'b1;
    tick();
    reg_write = 1'b0;
    op = 2'b01; tb_en = 1'b1;
    rd1_check("store_no_write_r3", 4'd3, 32'hDEAD_BEEF);

    // R0 protection.
    load(4'd0, 32'h1234_5678, 2'b00);
    rd1_check("r0_stays_zero", 4'd0, 32'h0);

    // Reset in the same cycle as an ALU write: reset wins and everything clears.
    op = 2'b10; rr1 = 4'd3; rr2 = 4'd6; wr = 4'd10; reg_write = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; reg_write = 1'b0; op = 2'b01;
    for (int i = 0; i < 16; i++) begin
      rd1_check("reset_mid_op", 4'(i), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
